// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the 5-stage pipeline front end
//               (next-PC sequencer state encoding, default vectors, register
//               zero index, PC increment and a saturating increment helper).
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_BOOT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_IMEM_WAIT = 2'd2,
        ST_EXC_DRAIN = 2'd3
    } seq_state_t;

    localparam logic [31:0] RESET_VECTOR_DFLT = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DFLT   = 32'h8000_0180;
    localparam logic [4:0]  REG_ZERO          = 5'd0;
    localparam logic [31:0] PC_STEP           = 32'd4;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use hazard detector. Flags when the load
//               in ID/EX writes a register the ID-stage instruction reads.
//               Register zero never creates a dependency.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       i_idex_mem_read,
    input  logic [4:0] i_idex_rt,
    input  logic [4:0] i_ifid_rs,
    input  logic [4:0] i_ifid_rt,
    output logic       o_load_use
);

    // Dependency on a pending load result
    assign o_load_use = i_idex_mem_read && (i_idex_rt != REG_ZERO) &&
                        ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Next-PC controller. Arbitrates sequential fetch, EX branch
//               redirect, ID jump, exception vectoring, load-use stall and
//               instruction-memory wait. Redirects arriving while imem is
//               busy are parked in a pending register until fetch accepts.
//               Optional macro PCSEQ_PERF_CNT_EN adds saturating stall,
//               flush and exception counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DFLT,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DFLT,
    parameter int          EXC_DRAIN    = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_pc_cur,
    input  logic        i_imem_ready,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_exc_req,
    input  logic        i_idex_mem_read,
    input  logic [4:0]  i_idex_rt,
    input  logic [4:0]  i_ifid_rs,
    input  logic [4:0]  i_ifid_rt,
`ifdef PCSEQ_PERF_CNT_EN
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt,
    output logic [31:0] o_exc_cnt,
`endif
    output logic [31:0] o_pc_next,
    output logic        o_pc_write,
    output logic        o_ifid_write,
    output logic        o_ifid_flush,
    output logic        o_idex_flush
);

    // Counter is loaded with EXC_DRAIN-1 so that vectoring happens on the
    // EXC_DRAIN-th cycle after the exception is taken.
    localparam logic [2:0] DRAIN_INIT = 3'(EXC_DRAIN - 1);

    seq_state_t  r_state, w_next_state;
    logic [2:0]  r_drain, w_drain_nxt;
    logic        r_pend_vld, w_pend_vld_nxt;
    logic [31:0] r_pend_addr, w_pend_addr_nxt;

    logic        w_load_use;
    logic        w_redirect;
    logic [31:0] w_redirect_tgt;
    logic [31:0] w_pc_seq;

    hazard_detect u_hazard_detect (
        .i_idex_mem_read (i_idex_mem_read),
        .i_idex_rt       (i_idex_rt),
        .i_ifid_rs       (i_ifid_rs),
        .i_ifid_rt       (i_ifid_rt),
        .o_load_use      (w_load_use)
    );

    // Branch outranks jump when both are present
    assign w_redirect     = i_branch_taken || i_jump;
    assign w_redirect_tgt = i_branch_taken ? i_branch_target : i_jump_target;
    assign w_pc_seq       = i_pc_cur + PC_STEP;

    // State, drain counter and pending-redirect registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_BOOT;
            r_drain     <= 3'd0;
            r_pend_vld  <= 1'b0;
            r_pend_addr <= 32'd0;
        end else begin
            r_state     <= w_next_state;
            r_drain     <= w_drain_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_addr <= w_pend_addr_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next_state    = r_state;
        w_drain_nxt     = r_drain;
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_addr_nxt = r_pend_addr;
        o_pc_next       = w_pc_seq;
        o_pc_write      = 1'b0;
        o_ifid_write    = 1'b0;
        o_ifid_flush    = 1'b0;
        o_idex_flush    = 1'b0;

        case (r_state)
            ST_BOOT: begin
                o_pc_next    = RESET_VECTOR;
                o_pc_write   = 1'b1;
                o_ifid_flush = 1'b1;
                o_idex_flush = 1'b1;
                w_next_state = ST_RUN;
            end

            ST_RUN: begin
                o_ifid_write = 1'b1;
                if (i_exc_req) begin
                    o_ifid_flush   = 1'b1;
                    o_idex_flush   = 1'b1;
                    w_pend_vld_nxt = 1'b0;
                    w_drain_nxt    = DRAIN_INIT;
                    w_next_state   = ST_EXC_DRAIN;
                end else if (w_redirect) begin
                    o_ifid_flush = 1'b1;
                    o_idex_flush = i_branch_taken;
                    if (i_imem_ready) begin
                        o_pc_next  = w_redirect_tgt;
                        o_pc_write = 1'b1;
                    end else begin
                        o_ifid_write    = 1'b0;
                        w_pend_vld_nxt  = 1'b1;
                        w_pend_addr_nxt = w_redirect_tgt;
                        w_next_state    = ST_IMEM_WAIT;
                    end
                end else if (w_load_use) begin
                    o_ifid_write = 1'b0;
                    o_idex_flush = 1'b1;
                end else if (r_pend_vld) begin
                    if (i_imem_ready) begin
                        o_pc_next      = r_pend_addr;
                        o_pc_write     = 1'b1;
                        w_pend_vld_nxt = 1'b0;
                    end else begin
                        o_ifid_write = 1'b0;
                    end
                end else begin
                    if (i_imem_ready) begin
                        o_pc_write = 1'b1;
                    end else begin
                        o_ifid_write = 1'b0;
                    end
                end
            end

            ST_IMEM_WAIT: begin
                o_idex_flush = 1'b1;
                if (i_exc_req) begin
                    o_ifid_flush   = 1'b1;
                    w_pend_vld_nxt = 1'b0;
                    w_drain_nxt    = DRAIN_INIT;
                    w_next_state   = ST_EXC_DRAIN;
                end else begin
                    if (w_redirect) begin
                        o_ifid_flush    = 1'b1;
                        w_pend_vld_nxt  = 1'b1;
                        w_pend_addr_nxt = w_redirect_tgt;
                    end
                    if (i_imem_ready) begin
                        w_next_state = ST_RUN;
                    end
                end
            end

            ST_EXC_DRAIN: begin
                o_ifid_flush = 1'b1;
                o_idex_flush = 1'b1;
                if (r_drain == 3'd0) begin
                    o_pc_next    = EXC_VECTOR;
                    o_pc_write   = 1'b1;
                    w_next_state = ST_RUN;
                end else begin
                    w_drain_nxt = r_drain - 3'd1;
                end
            end

            default: begin
                w_next_state = ST_BOOT;
            end
        endcase

        // Reset forces safe outputs even though the state already reads BOOT
        if (rst) begin
            o_pc_next    = RESET_VECTOR;
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end
    end

`ifdef PCSEQ_PERF_CNT_EN
    logic        w_live;
    logic        w_stall_ev;
    logic        w_flush_ev;
    logic        w_exc_ev;
    logic [31:0] r_stall_cnt, r_flush_cnt, r_exc_cnt;

    assign w_live     = (r_state == ST_RUN) || (r_state == ST_IMEM_WAIT);
    assign w_exc_ev   = w_live && i_exc_req;
    assign w_stall_ev = w_live && !i_exc_req && (w_load_use || !i_imem_ready);
    assign w_flush_ev = (r_state == ST_RUN) && !i_exc_req && i_imem_ready &&
                        (w_redirect || (!w_load_use && r_pend_vld));

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
            r_exc_cnt   <= 32'd0;
        end else begin
            if (w_stall_ev) r_stall_cnt <= sat_inc(r_stall_cnt);
            if (w_flush_ev) r_flush_cnt <= sat_inc(r_flush_cnt);
            if (w_exc_ev)   r_exc_cnt   <= sat_inc(r_exc_cnt);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
    assign o_exc_cnt   = r_exc_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the 5-stage pipeline. Drives the program counter's next-value and write-enable inputs, and the IF/ID and ID/EX control strobes. Arbitrates between sequential fetch, EX-stage branch redirect, ID-stage jump, exception vectoring, load-use hazard stall and instruction-memory wait. Holds any redirect that arrives while imem is busy until fetch can accept it.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value issued in BOOT state
EXC_VECTOR, 32'h8000_0180, exception handler address
EXC_DRAIN, 2, cycles of pipeline flush before vectoring (range 1..7)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
pc_cur  in  32  current PC register value
imem_ready  in  1  instruction memory returned word for pc_cur this cycle
branch_taken  in  1  EX-stage branch resolved taken
branch_target  in  32  EX-stage branch target
jump  in  1  ID-stage jump decoded
jump_target  in  32  ID-stage jump target
exc_req  in  1  exception raised (single-cycle pulse)
idex_mem_read  in  1  instruction in ID/EX is a load
idex_rt  in  5  load destination register
ifid_rs  in  5  ID-stage source rs
ifid_rt  in  5  ID-stage source rt
pc_next  out  32  next PC value to the PC register
pc_write  out  1  PC register write enable
ifid_write  out  1  IF/ID register write enable
ifid_flush  out  1  zero IF/ID contents
idex_flush  out  1  insert bubble into ID/EX

Behaviour:
- States: BOOT, RUN, IMEM_WAIT, EXC_DRAIN. State, drain counter and pending-redirect register {pend_vld, pend_addr[31:0]} are sequential. All outputs are combinational from state and inputs.
- Reset (async, any state, including mid-drain or mid-wait): state=BOOT, pend_vld=0, drain counter=0. While rst high: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pc_next=RESET_VECTOR.
- BOOT (one cycle): pc_next=RESET_VECTOR, pc_write=1, ifid_flush=1, idex_flush=1 -> RUN.
- load_use = idex_mem_read & (idex_rt!=0) & (idex_rt==ifid_rs | idex_rt==ifid_rt).
- RUN priority, highest first:
  1 exc_req: pc_write=0, ifid_flush=1, idex_flush=1, pend_vld cleared, counter=EXC_DRAIN-1 -> EXC_DRAIN.
  2 branch_taken: target=branch_target, ifid_flush=1, idex_flush=1.
  3 jump: target=jump_target, ifid_flush=1.
  4 load_use: pc_write=0, ifid_write=0, idex_flush=1. Redirects never coincide with load_use at lower priority.
  5 pend_vld: target=pend_addr.
  6 otherwise: target=pc_cur+32'd4 (mod 2^32, wraps FFFF_FFFC->0).
- Cases 2, 3, 5 and 6 apply only when imem_ready=1: pc_next=target, pc_write=1, ifid_write=1, and pend_vld is cleared if case 5. With imem_ready=0: pc_write=0, ifid_write=0. A branch or jump target is latched into pend (branch overwrites jump, a new redirect overwrites the old pend), the flushes above still assert, and state -> IMEM_WAIT.
- IMEM_WAIT: pc_write=0, ifid_write=0, idex_flush=1. A branch_taken or jump arriving here overwrites pend with the same priority. On imem_ready=1 -> RUN; pend is consumed there by case 5 next cycle. exc_req takes priority and behaves as in RUN.
- EXC_DRAIN: ifid_flush=1, idex_flush=1, pc_write=0, and all redirect and hazard inputs are ignored. The counter decrements each cycle. When counter==0: pc_next=EXC_VECTOR, pc_write=1 -> RUN. A second exc_req during drain is ignored.
- ifid_write defaults to 1 in RUN except where stated, and to 0 in all other states. idex_flush and ifid_flush default to 0 in RUN.

Optional Feature:
PCSEQ_PERF_CNT_EN
- Defined: adds outputs stall_cnt[31:0], flush_cnt[31:0] and exc_cnt[31:0].
  - stall_cnt increments on each cycle with load_use or imem_ready=0 in RUN/IMEM_WAIT.
  - flush_cnt increments on each accepted branch or jump redirect.
  - exc_cnt increments on each EXC_DRAIN entry.
  - All counters are cleared by rst and saturate at FFFF_FFFF.
- Undefined: ports and logic are absent, with no other change.

Decomposition:
- Shared package pipe_pkg: state enum encodings (BOOT=2'd0, RUN=2'd1, IMEM_WAIT=2'd2, EXC_DRAIN=2'd3), the default vectors as constants, and the REG_ZERO=5'd0 constant.
- One sub-module is natural: hazard_detect, which is combinational, computes load_use, and is reusable by the forwarding unit.

Test Plan:
- Reset release, imem_ready=1 -> BOOT cycle writes 0, then pc_next=4, 8, 12 on successive cycles.
- pc_cur=0x40, idex_mem_read=1, idex_rt=5, ifid_rs=5 for 1 cycle -> pc_write=0, ifid_write=0, idex_flush=1. idex_rt=0 with the same inputs -> no stall.
- pc_cur=0x100 with branch_taken and jump both high, targets 0x200 and 0x300 -> pc_next=0x200, both flushes=1.
- jump to 0x500 with imem_ready=0 for 3 cycles -> pc_write=0 for 3 cycles, then pc_next=0x500 on the first cycle after ready returns to RUN.
- exc_req in RUN with EXC_DRAIN=2 -> 2 flush cycles with pc_write=0, then pc_next=0x8000_0180, pc_write=1. A branch_taken during drain is ignored.
- pc_cur=0xFFFF_FFFC sequential -> pc_next=0. Assert rst mid-EXC_DRAIN -> outputs immediately at reset values, BOOT after release.
